// File: rtl/frame_pixel_feeder.sv
// Upstream pixel feeder: frame-synchronises the RGB565 camera stream, buffers it
// in a small FIFO and tags each head pixel with raster and block coordinates.
// Framing problems raise a sticky error flag that drives the error overlay.
module frame_pixel_feeder #(
  parameter int FRAME_W = 320,
  parameter int FRAME_H = 240,
  parameter int BLK     = 20,
  parameter int DEPTH   = 4,
  parameter int DW      = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [DW-1:0] s_data,
  input  logic          s_valid,
  input  logic          s_sop,
  input  logic          s_eop,
  output logic          s_ready,
  output logic [DW-1:0] m_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [8:0]    x,
  output logic [7:0]    y,
  output logic [3:0]    blk_col,
  output logic [3:0]    blk_row,
  output logic [7:0]    blk_idx,
  output logic          frame_start,
  output logic          frame_done,
  output logic          frame_err
);
  localparam int AW = $clog2(DEPTH);
  localparam int GW = FRAME_W / BLK;
  localparam int SW = (BLK > 1) ? $clog2(BLK) : 1;

  // Each entry carries {sop, eop, pixel}
  logic [DW+1:0] mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   count;
  logic          in_frame;

  // Coordinate state for the next pixel after the last pop
  logic [8:0]    x_r;
  logic [7:0]    y_r;
  logic [3:0]    bc_r, br_r;
  logic [SW-1:0] xs_r, ys_r;
  logic [7:0]    rb_r;

  logic          accept, push, pop, head_sop, head_eop, at_last;
  logic [SW-1:0] xs, ys;
  logic [7:0]    rb;
  logic          err_set, err_clr;

  assign s_ready  = (count != (AW+1)'(DEPTH));
  assign m_valid  = (count != '0);
  assign accept   = s_valid && s_ready;
  // Beats ahead of the first sop are swallowed so the FIFO only holds framed data
  assign push     = accept && (in_frame || s_sop);
  assign pop      = m_valid && m_ready;
  assign m_data   = mem[rptr][DW-1:0];
  assign head_sop = m_valid && mem[rptr][DW+1];
  assign head_eop = mem[rptr][DW];

  // A sop head always sits at the frame origin, whatever the counters say
  assign x       = head_sop ? '0 : x_r;
  assign y       = head_sop ? '0 : y_r;
  assign blk_col = head_sop ? '0 : bc_r;
  assign blk_row = head_sop ? '0 : br_r;
  assign xs      = head_sop ? '0 : xs_r;
  assign ys      = head_sop ? '0 : ys_r;
  assign rb      = head_sop ? '0 : rb_r;
  // rb tracks blk_row*GW incrementally, so the index is a single add
  assign blk_idx = rb + {4'b0, blk_col};
  assign at_last = (x == 9'(FRAME_W-1)) && (y == 8'(FRAME_H-1));

  assign err_set = (accept && s_sop && in_frame)
                 || (pop && head_eop && !at_last)
                 || (pop && at_last && !head_eop);
  assign err_clr = pop && head_sop;

  // FIFO storage, written on push only
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= {s_sop, s_eop, s_data};
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (!push && pop) count <= count - 1'b1;
    end
  end

  // Input framing state: sop opens a frame, eop closes it (eop wins on a 1-beat frame)
  always_ff @(posedge clk) begin
    if (reset) in_frame <= 1'b0;
    else if (accept) begin
      if (s_eop)      in_frame <= 1'b0;
      else if (s_sop) in_frame <= 1'b1;
    end
  end

  // Coordinate tracker advances from the (possibly forced) head coordinates on each pop
  always_ff @(posedge clk) begin
    if (reset) begin
      x_r <= '0; y_r <= '0; bc_r <= '0; br_r <= '0;
      xs_r <= '0; ys_r <= '0; rb_r <= '0;
    end else if (pop) begin
      if (head_eop || at_last) begin
        x_r <= '0; y_r <= '0; bc_r <= '0; br_r <= '0;
        xs_r <= '0; ys_r <= '0; rb_r <= '0;
      end else if (x == 9'(FRAME_W-1)) begin
        x_r  <= '0;
        xs_r <= '0;
        bc_r <= '0;
        y_r  <= y + 8'd1;
        if (ys == SW'(BLK-1)) begin
          ys_r <= '0;
          br_r <= blk_row + 4'd1;
          rb_r <= rb + 8'(GW);
        end else begin
          ys_r <= ys + SW'(1);
          br_r <= blk_row;
          rb_r <= rb;
        end
      end else begin
        x_r  <= x + 9'd1;
        y_r  <= y;
        ys_r <= ys;
        br_r <= blk_row;
        rb_r <= rb;
        if (xs == SW'(BLK-1)) begin
          xs_r <= '0;
          bc_r <= blk_col + 4'd1;
        end else begin
          xs_r <= xs + SW'(1);
          bc_r <= blk_col;
        end
      end
    end
  end

  // Registered frame pulses and sticky error (a new error beats the sop clear)
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      frame_start <= pop && head_sop;
      frame_done  <= pop && at_last;
      if (err_set)      frame_err <= 1'b1;
      else if (err_clr) frame_err <= 1'b0;
    end
  end
endmodule

// File: tb/tb_frame_pixel_feeder.sv
// Directed bench for frame_pixel_feeder on a reduced 40x24 frame with 4x4 blocks
// (10x6 grid). Every popped pixel is checked against an expected-pixel queue.
module tb_frame_pixel_feeder;
  localparam int W = 40, H = 24, B = 4, D = 4, NP = W*H, GW = W/B;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] s_data;
  logic        s_valid, s_sop, s_eop, s_ready;
  logic [15:0] m_data;
  logic        m_valid, m_ready;
  logic [8:0]  x;
  logic [7:0]  y;
  logic [3:0]  blk_col, blk_row;
  logic [7:0]  blk_idx;
  logic        frame_start, frame_done, frame_err;

  int n_tests = 0, n_fail = 0, fs_cnt = 0, fd_cnt = 0;

  typedef struct { logic [15:0] d; int i; } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  frame_pixel_feeder #(.FRAME_W(W), .FRAME_H(H), .BLK(B), .DEPTH(D), .DW(16)) dut (
    .clk(clk), .reset(reset),
    .s_data(s_data), .s_valid(s_valid), .s_sop(s_sop), .s_eop(s_eop), .s_ready(s_ready),
    .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .x(x), .y(y), .blk_col(blk_col), .blk_row(blk_row), .blk_idx(blk_idx),
    .frame_start(frame_start), .frame_done(frame_done), .frame_err(frame_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Pop monitor: sampled just after the falling edge, ahead of the popping edge
  always begin
    @(negedge clk);
    #1;
    if (!reset) begin
      fs_cnt += int'(frame_start);
      fd_cnt += int'(frame_done);
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) chk("spurious_pop", 32'(m_valid), 0);
        else begin
          exp_t e;
          int ex, ey;
          e  = exp_q.pop_front();
          ex = e.i % W;
          ey = e.i / W;
          chk("data", m_data, e.d);
          chk("x", x, ex);
          chk("y", y, ey);
          chk("blk_col", blk_col, ex / B);
          chk("blk_row", blk_row, ey / B);
          chk("blk_idx", blk_idx, (ey / B) * GW + ex / B);
        end
      end
    end
  end

  // Offer one beat (called at a falling edge); returns at the falling edge after acceptance
  task automatic send(input logic [15:0] d, input logic sop, input logic eop,
                      input logic keep, input int i);
    int t = 0;
    s_data = d; s_sop = sop; s_eop = eop; s_valid = 1'b1;
    while (!s_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) chk("send_timeout", 32'(s_ready), 1);
    if (keep) exp_q.push_back('{d, i});
    @(negedge clk);
    s_valid = 1'b0; s_sop = 1'b0; s_eop = 1'b0;
  endtask

  // Beats first..n-1 of frame fid; sop on beat 0, eop on beat eop_at (-1: none)
  task automatic run_frame(input int fid, input int first, input int n, input int eop_at);
    for (int i = first; i < n; i++) begin
      send(16'((fid << 12) | i), i == 0, i == eop_at, 1'b1, i);
      if (i == 0) chk("lat_valid", 32'(m_valid), 1);
    end
  endtask

  task automatic drain();
    int t = 0;
    while (m_valid && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) chk("drain_timeout", 32'(m_valid), 0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; s_data = '0; s_valid = 1'b0; s_sop = 1'b0; s_eop = 1'b0; m_ready = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst_m_valid", 32'(m_valid), 0);
    chk("rst_s_ready", 32'(s_ready), 1);
    chk("rst_x", x, 0);
    chk("rst_y", y, 0);
    chk("rst_blk_idx", blk_idx, 0);
    chk("rst_err", 32'(frame_err), 0);
    chk("rst_start", 32'(frame_start), 0);
    chk("rst_done", 32'(frame_done), 0);

    // Pre-sync garbage must be dropped, then a clean frame
    for (int i = 0; i < 10; i++) send(16'hbad0 | 16'(i), 1'b0, 1'b0, 1'b0, 0);
    chk("garbage_empty", 32'(m_valid), 0);
    run_frame(1, 0, NP, NP-1);
    drain();
    chk("f1_start", fs_cnt, 1);
    chk("f1_done", fd_cnt, 1);
    chk("f1_err", 32'(frame_err), 0);

    // Backpressure: 4 beats fill the FIFO, head holds while stalled
    m_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(16'((2 << 12) | i), i == 0, 1'b0, 1'b1, i);
    chk("full_s_ready", 32'(s_ready), 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("stall_data", m_data, 16'h2000);
      chk("stall_valid", 32'(m_valid), 1);
    end
    fork
      begin repeat (2) @(negedge clk); m_ready = 1'b1; end
    join_none
    run_frame(2, 4, NP, NP-1);
    drain();
    chk("f2_start", fs_cnt, 2);
    chk("f2_done", fd_cnt, 2);
    chk("f2_err", 32'(frame_err), 0);

    // Early eop: error, no frame_done; next clean frame clears it
    run_frame(3, 0, 101, 100);
    drain();
    chk("eop_err", 32'(frame_err), 1);
    chk("eop_no_done", fd_cnt, 2);
    run_frame(4, 0, NP, NP-1);
    drain();
    chk("f4_err_clr", 32'(frame_err), 0);
    chk("f4_start", fs_cnt, 4);
    chk("f4_done", fd_cnt, 3);

    // Truncated frame: sop while still in frame
    run_frame(5, 0, 50, -1);
    m_ready = 1'b0;
    send(16'(6 << 12), 1'b1, 1'b0, 1'b1, 0);
    chk("trunc_err", 32'(frame_err), 1);
    m_ready = 1'b1;
    run_frame(6, 1, NP, NP-1);
    drain();
    chk("f6_err_clr", 32'(frame_err), 0);
    chk("f6_start", fs_cnt, 6);
    chk("f6_done", fd_cnt, 4);

    // Reset mid-frame with a full FIFO
    run_frame(7, 0, 30, -1);
    drain();
    m_ready = 1'b0;
    for (int i = 30; i < 34; i++) send(16'((7 << 12) | i), 1'b0, 1'b0, 1'b1, i);
    chk("rst2_full", 32'(s_ready), 0);
    reset = 1'b1;
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
    chk("rst2_m_valid", 32'(m_valid), 0);
    chk("rst2_s_ready", 32'(s_ready), 1);
    chk("rst2_x", x, 0);
    chk("rst2_y", y, 0);
    chk("rst2_blk_idx", blk_idx, 0);
    m_ready = 1'b1;
    for (int i = 0; i < 3; i++) send(16'h7f00 | 16'(i), 1'b0, 1'b0, 1'b0, 0);
    chk("rst2_dropped", 32'(m_valid), 0);
    run_frame(8, 0, NP, NP-1);
    drain();
    chk("f8_start", fs_cnt, 8);
    chk("f8_done", fd_cnt, 5);
    chk("f8_err", 32'(frame_err), 0);
    chk("exp_q_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
